// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_if
// Brief    : Controller handshake and SPI pin bundle for spi_master.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss_n;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sclk, mosi, ss_n
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sclk, mosi, ss_n
  );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : SPI mode-0 master, one 8-bit MSB-first full-duplex transfer per
//            start, with ss_n lead/trail/gap guard times of CLK_DIV cycles.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  spi_master_if.master bus
);

  localparam int                 c_CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LEAD  = 3'd1;
  localparam logic [2:0] c_XFER  = 3'd2;
  localparam logic [2:0] c_TRAIL = 3'd3;
  localparam logic [2:0] c_GAP   = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sclk;
  logic [7:0]         r_tx;
  logic [7:0]         r_rx;
  logic [7:0]         r_rx_data;
  logic [2:0]         r_bits;
  logic               r_done;
  logic               w_tick;
  logic               w_accept;

  assign w_tick   = (r_cnt == c_CNT_MAX);
  // The last GAP cycle doubles as the first idle cycle, so a held start
  // relaunches with exactly CLK_DIV cycles of ss_n high.
  assign w_accept = bus.start && ((r_state == c_IDLE) || ((r_state == c_GAP) && w_tick));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = c_LEAD;
      c_LEAD:  if (w_tick) w_state_nxt = c_XFER;
      c_XFER:  if (w_tick && r_sclk && (r_bits == 3'd7)) w_state_nxt = c_TRAIL;
      c_TRAIL: if (w_tick) w_state_nxt = c_GAP;
      c_GAP:   if (w_tick) w_state_nxt = w_accept ? c_LEAD : c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    bus.ss_n = 1'b1;
    bus.busy = 1'b0;
    bus.mosi = 1'b0;
    case (r_state)
      c_LEAD, c_XFER: begin
        bus.ss_n = 1'b0;
        bus.busy = 1'b1;
        bus.mosi = r_tx[7];
      end
      c_TRAIL: begin
        bus.ss_n = 1'b0;
        bus.busy = 1'b1;
      end
      c_GAP:   bus.busy = 1'b1;
      default: ;
    endcase
  end

  assign bus.sclk    = r_sclk;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sclk    <= 1'b0;
      r_tx      <= 8'h00;
      r_rx      <= 8'h00;
      r_rx_data <= 8'h00;
      r_bits    <= 3'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == c_IDLE) || w_tick) r_cnt <= '0;
      else                               r_cnt <= r_cnt + c_CNT_W'(1);

      if (w_accept) begin
        r_tx   <= bus.tx_data;
        r_bits <= 3'd0;
        r_sclk <= 1'b0;
      end else if (w_tick) begin
        case (r_state)
          c_LEAD: begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[6:0], bus.miso};
          end
          c_XFER: begin
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              r_rx <= {r_rx[6:0], bus.miso};
            end else begin
              r_tx   <= {r_tx[6:0], 1'b0};
              r_bits <= r_bits + 3'd1;
            end
          end
          c_TRAIL: begin
            r_rx_data <= r_rx;
            r_done    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

SPI mode-0 (CPOL=0, CPHA=0) single-chip-select master. It is the initiating end for the team's 8-bit SPI slave. It runs one 8-bit MSB-first full-duplex transfer per `start` request and generates `sclk` by dividing `clk`. It also drives `ss_n` with lead and trail guard times and returns the received byte with a one-cycle `done` pulse. The block sits between a local controller (register file or sequencer) and the SPI pins.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period. Legal range is ≥1, so `sclk` period = 2·`CLK_DIV` clk cycles.

Ports:
- `clk`  in  1  system clock; all logic is synchronous to it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  transfer request, sampled only when `busy`=0.
- `tx_data`  in  8  byte to send, latched in the cycle `start` is accepted.
- `rx_data`  out  8  last received byte, updated together with `done`.
- `busy`  out  1  high from the cycle after acceptance until the transfer, including the gap, completes.
- `done`  out  1  single-cycle pulse; `rx_data` is valid from this cycle.
- `sclk`  out  1  SPI clock, idle low.
- `mosi`  out  1  serial data out, MSB first.
- `miso`  in  1  serial data in.
- `ss_n`  out  1  slave select, active low.

## Operation
- FSM states: IDLE, LEAD, XFER, TRAIL, GAP. A half-period counter `cnt` (0..CLK_DIV-1) runs in every non-IDLE state.
- IDLE:
  - Outputs: `ss_n`=1, `sclk`=0, `mosi`=0, `busy`=0.
  - When `start`=1, the block latches `tx_data` into the shift register, sets `ss_n`=0, `mosi`=tx[7], `busy`=1, `cnt`=0, and moves to LEAD.
- LEAD: waits CLK_DIV cycles with `sclk` low, then sets `sclk`=1, samples `miso` into the rx shift register LSB (shifting left), and moves to XFER.
- XFER: `sclk` toggles every CLK_DIV cycles.
  - At each rising edge (`sclk` 0→1), the block samples `miso` at that same clk edge.
  - At each falling edge (`sclk` 1→0), `mosi` advances to the next lower tx bit.
  - After the 8th falling edge, `mosi`=0 and the FSM moves to TRAIL.
  - Exactly 8 rising and 8 falling edges are produced per transfer.
- TRAIL: after CLK_DIV cycles with `sclk` low, the block sets `ss_n`=1, `rx_data` = the 8 sampled bits (first sample is the MSB), `done`=1 for one cycle, and moves to GAP.
- GAP: `ss_n` stays high for CLK_DIV cycles; then `busy`=0 and the FSM returns to IDLE.
- A `start` pulse while `busy`=1 is ignored and is not queued. A `start` held high launches the next transfer in the first IDLE cycle.
- `tx_data` changes after acceptance do not affect the transfer in progress.
- `rx_data` holds its value between transfers.

## Timing
- Reset values: `sclk`=0, `mosi`=0, `ss_n`=1, `busy`=0, `done`=0, `rx_data`=0. FSM=IDLE, `cnt`=0, shift registers 0.
- Asserting `rst_n` mid-transfer forces the reset values immediately: `ss_n` rises asynchronously, no `done` is issued, and no partial `rx_data` update occurs. After release, the block is in IDLE and accepts `start` on the first clk edge.
- Let E0 be the clk edge that accepts `start`:
  - `ss_n` falls at E0.
  - k-th rising `sclk` edge (k=0..7) at E0+(2k+1)·CLK_DIV.
  - k-th falling edge at E0+(2k+2)·CLK_DIV.
  - `done`/`ss_n` rise at E0+17·CLK_DIV.
  - `busy` falls at E0+18·CLK_DIV.
  - Next acceptance no earlier than E0+18·CLK_DIV.
- Guard times: `ss_n`-low to first `sclk` rise = CLK_DIV cycles; last `sclk` fall to `ss_n` rise = CLK_DIV cycles; minimum `ss_n`-high time between transfers = CLK_DIV cycles.
- Bit validity: `mosi` is stable for a full half-period before and after each rising `sclk` edge.
- `miso` is assumed to be stable at the rising `sclk` edge. No synchronizer is used, because `sclk` is generated from `clk`.
- CLK_DIV=1: `sclk`=clk/2; the same formulas hold (done at E0+17, busy low at E0+18).

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs at their reset values; `start` ignored until release.
- Loopback (`miso` tied to `mosi`), CLK_DIV=4, `tx_data`=0xA5, `start` pulse at E0:
  - `done` at E0+68, `rx_data`=0xA5, `busy` low at E0+72.
  - Exactly 8 `sclk` rises, the first at E0+4.
- Mode-0 slave model loaded with 0x3C, master sends 0xC3 → slave receives 0xC3, `rx_data`=0x3C, and the `mosi` bit sequence is 1,1,0,0,0,0,1,1.
- `start` re-pulsed at E0+10 with `tx_data`=0xFF during a 0x12 transfer → ignored; exactly one `done`; `rx_data` in loopback = 0x12.
- `start` held high, `tx_data`=0x81 then 0x7E:
  - Two transfers; the second `ss_n` fall occurs at E0+72 after CLK_DIV cycles of `ss_n` high.
  - `done` twice, with `rx_data` 0x81 then 0x7E.
- `rst_n` asserted at E0+30 → `ss_n`=1 and `sclk`=0 immediately, no `done`, `rx_data` unchanged from its prior value (0). A new transfer after release completes normally. Repeat the loopback case with CLK_DIV=1: `done` at E0+17.
